// File: rtl/wb_queue.sv
// Buffered writeback stage: round-robin arbitration over NSRC producers, a DEPTH-entry
// FIFO of register writes drained one per cycle, and a forwarding lookup over pending writes.
module wb_queue #(
  parameter int         NSRC      = 2,
  parameter int         DEPTH     = 4,
  parameter int         XLEN      = 32,
  parameter logic [6:0] JMPC_TYPE = 7'h6F,
  parameter logic [6:0] SAVE_TYPE = 7'h23
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   port_busy,
  input  logic [NSRC-1:0]        src_valid,
  output logic [NSRC-1:0]        src_ready,
  input  logic [NSRC*5-1:0]      src_rd_addr,
  input  logic [NSRC*XLEN-1:0]   src_rd_val,
  input  logic [NSRC*7-1:0]      src_ins_type,
  output logic                   write_enable,
  output logic [4:0]             write_addr,
  output logic [XLEN-1:0]        write_data,
  input  logic [4:0]             fwd_addr,
  output logic                   fwd_hit,
  output logic [XLEN-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         RRW      = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [RRW-1:0]   rr;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       mem_addr [DEPTH];
  logic [XLEN-1:0]  mem_data [DEPTH];

  logic [NSRC-1:0]  writing;
  logic [NSRC-1:0]  grant;
  logic             found;
  logic             sel_wr;
  logic [RRW-1:0]   gidx;
  logic [4:0]       sel_addr;
  logic [XLEN-1:0]  sel_val;
  logic             full;
  logic             pop;
  logic             hs;
  logic             push;

  always_comb begin
    writing = '0;
    for (int i = 0; i < NSRC; i++) begin
      writing[i] = (src_ins_type[7*i +: 7] != JMPC_TYPE) &&
                   (src_ins_type[7*i +: 7] != SAVE_TYPE) &&
                   (src_rd_addr[5*i +: 5] != 5'd0);
    end
  end

  // First valid source at or after rr, scanning cyclically
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_val  = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && src_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = RRW'(idx);
        sel_wr     = writing[idx];
        sel_addr   = src_rd_addr[5*idx +: 5];
        sel_val    = src_rd_val[XLEN*idx +: XLEN];
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = rdy_in & ~port_busy & ~empty;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = rdy_in & grant[i] & (~writing[i] | ~full | pop);
    end
  end

  assign hs   = |src_ready;
  assign push = hs & sel_wr;

  // Stage p0 -> p1: queue control and registered write port
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr           <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_vld      <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (rdy_in) begin
      if (pop) begin
        write_enable  <= 1'b1;
        write_addr    <= mem_addr[head];
        write_data    <= mem_data[head];
        ent_vld[head] <= 1'b0;
        head          <= head + AW'(1);
      end else begin
        write_enable <= 1'b0;
        write_addr   <= '0;
        write_data   <= '0;
      end
      // A full-queue push lands on the slot just vacated, so it must win
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + AW'(1);
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (hs) rr <= (gidx == RRW'(NSRC-1)) ? '0 : gidx + RRW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_addr[tail] <= sel_addr;
      mem_data[tail] <= sel_val;
    end
  end

  // Scan oldest to youngest so the last match is the youngest pending value
  always_comb begin
    logic [AW-1:0] pos;
    logic          q_hit;
    pos      = '0;
    q_hit    = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != 5'd0) begin
      for (int k = 0; k < DEPTH; k++) begin
        pos = head + AW'(k);
        if (ent_vld[pos] && (mem_addr[pos] == fwd_addr)) begin
          q_hit    = 1'b1;
          fwd_data = mem_data[pos];
        end
      end
      if (q_hit) begin
        fwd_hit = 1'b1;
      end else if (write_enable && (write_addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected writes are queued as stimulus is accepted
// and compared in order against writes seen on the register-file port.
module tb_wb_queue;

  localparam logic [6:0] ALU  = 7'h33;
  localparam logic [6:0] JMPC = 7'h6F;
  localparam logic [6:0] SAVE = 7'h23;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        port_busy;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [9:0]  src_rd_addr;
  logic [63:0] src_rd_val;
  logic [13:0] src_ins_type;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        empty;

  int  checks;
  int  errors;
  wr_t exp_q[$];
  wr_t obs_q[$];
  logic cap_rdy;
  logic cap_rst;

  wb_queue #(.NSRC(2), .DEPTH(4), .XLEN(32), .JMPC_TYPE(JMPC), .SAVE_TYPE(SAVE)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .port_busy(port_busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd_addr(src_rd_addr),
    .src_rd_val(src_rd_val), .src_ins_type(src_ins_type),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // A write is new only if the preceding edge was an active, non-reset cycle
  always @(posedge clk_in) begin
    cap_rdy <= rdy_in;
    cap_rst <= rst_in;
  end

  always @(negedge clk_in) begin
    if (write_enable === 1'b1 && cap_rdy === 1'b1 && cap_rst === 1'b0)
      obs_q.push_back('{a: write_addr, d: write_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd,
                         input logic [31:0] val, input logic [6:0] ty);
    src_valid[i]            = v;
    src_rd_addr[5*i +: 5]   = rd;
    src_rd_val[32*i +: 32]  = val;
    src_ins_type[7*i +: 7]  = ty;
  endtask

  task automatic do_reset();
    src_valid = '0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; port_busy = 1'b0; fwd_addr = '0;
    src_valid = '0; src_rd_addr = '0; src_rd_val = '0; src_ins_type = '0;
    tick(); tick();
    rst_in = 1'b0;
    #1;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_enable); end
    checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", write_addr); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", write_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", src_ready); end
  endtask

  task automatic test_single();
    wr_t e, o;
    set_src(0, 1'b1, 5'd5, 32'h0000_1234, ALU);
    #1;
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", src_ready); end
    exp_q.push_back('{a: 5'd5, d: 32'h0000_1234});
    tick();
    src_valid = '0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_we_early got %b want 0", write_enable); end
    tick();
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", write_enable); end
    checks++; if (write_addr !== 5'd5) begin errors++; $display("FAIL single_addr got %0d want 5", write_addr); end
    checks++; if (write_data !== 32'h0000_1234) begin errors++; $display("FAIL single_data got %h want 00001234", write_data); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained count %0d empty %b want 0 1", count, empty); end
    tick();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_we_clear got %b want 0", write_enable); end
    for (int n = 0; n < 30 && obs_q.size() < exp_q.size(); n++) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_sb got %0d/%h want %0d/%h", o.a, o.d, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_filter();
    logic [4:0] rds [3];
    logic [6:0] tys [3];
    rds[0] = 5'd0; tys[0] = ALU;
    rds[1] = 5'd3; tys[1] = SAVE;
    rds[2] = 5'd4; tys[2] = JMPC;
    for (int k = 0; k < 3; k++) begin
      set_src(0, 1'b1, rds[k], 32'hDEAD_0000 + 32'(k), tys[k]);
      #1;
      checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL filter_ready%0d got %b want 01", k, src_ready); end
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL filter_count%0d got %0d want 0", k, count); end
    end
    src_valid = '0;
    tick(); tick();
    checks++; if (obs_q.size() != 0 || write_enable !== 1'b0) begin errors++; $display("FAIL filter_nowrite got %0d writes we %b want 0 0", obs_q.size(), write_enable); end
    obs_q.delete();
  endtask

  task automatic test_round_robin();
    wr_t e, o;
    logic [1:0] want;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_src(0, 1'b1, 5'd1, 32'h1000 + 32'(k), ALU);
      set_src(1, 1'b1, 5'd2, 32'h2000 + 32'(k), ALU);
      #1;
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (src_ready !== want) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, src_ready, want); end
      if (k % 2 == 0) exp_q.push_back('{a: 5'd1, d: 32'h1000 + 32'(k)});
      else            exp_q.push_back('{a: 5'd2, d: 32'h2000 + 32'(k)});
      tick();
      if (k >= 1) begin
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rr_gap%0d got %b want 1", k, write_enable); end
      end
    end
    src_valid = '0;
    tick();
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rr_last got %b want 1", write_enable); end
    for (int n = 0; n < 30 && obs_q.size() < exp_q.size(); n++) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rr_sb got %0d/%h want %0d/%h", o.a, o.d, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_full();
    wr_t e, o;
    port_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_src(0, 1'b1, 5'(10 + k), 32'h3000 + 32'(k), ALU);
      #1;
      checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL full_fill%0d got %b want 01", k, src_ready); end
      exp_q.push_back('{a: 5'(10 + k), d: 32'h3000 + 32'(k)});
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    set_src(0, 1'b1, 5'd20, 32'h3020, ALU);
    #1;
    checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL full_block got %b want 00", src_ready); end
    set_src(0, 1'b1, 5'd21, 32'h3021, SAVE);
    #1;
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL full_save got %b want 01", src_ready); end
    tick();
    checks++; if (count !== 3'd4 || write_enable !== 1'b0) begin errors++; $display("FAIL full_save_count count %0d we %b want 4 0", count, write_enable); end
    set_src(0, 1'b1, 5'd22, 32'h3022, ALU);
    port_busy = 1'b0;
    #1;
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL full_pushpop_ready got %b want 01", src_ready); end
    exp_q.push_back('{a: 5'd22, d: 32'h3022});
    tick();
    src_valid = '0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got %0d want 4", count); end
    checks++; if (write_enable !== 1'b1 || write_addr !== 5'd10) begin errors++; $display("FAIL full_pushpop_write we %b addr %0d want 1 10", write_enable, write_addr); end
    for (int n = 0; n < 30 && obs_q.size() < exp_q.size(); n++) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL full_sb got %0d/%h want %0d/%h", o.a, o.d, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_forward();
    wr_t e, o;
    tick(); tick();
    port_busy = 1'b1;
    fwd_addr = 5'd7;
    set_src(0, 1'b1, 5'd7, 32'h0000_000A, ALU);
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %b want 0", fwd_hit); end
    exp_q.push_back('{a: 5'd7, d: 32'h0000_000A});
    tick();
    set_src(0, 1'b1, 5'd7, 32'h0000_000B, ALU);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_000A) begin errors++; $display("FAIL fwd_first hit %b data %h want 1 0000000a", fwd_hit, fwd_data); end
    exp_q.push_back('{a: 5'd7, d: 32'h0000_000B});
    tick();
    src_valid = '0;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_000B) begin errors++; $display("FAIL fwd_youngest hit %b data %h want 1 0000000b", fwd_hit, fwd_data); end
    fwd_addr = 5'd0;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_r0 got %b want 0", fwd_hit); end
    fwd_addr = 5'd8;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_miss hit %b data %h want 0 0", fwd_hit, fwd_data); end
    fwd_addr = 5'd7;
    port_busy = 1'b0;
    tick();
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_000B) begin errors++; $display("FAIL fwd_after_pop1 hit %b data %h want 1 0000000b", fwd_hit, fwd_data); end
    tick();
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_000B || count !== 3'd0) begin errors++; $display("FAIL fwd_wport hit %b data %h count %0d want 1 0000000b 0", fwd_hit, fwd_data, count); end
    tick();
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_gone got %b want 0", fwd_hit); end
    fwd_addr = 5'd0;
    for (int n = 0; n < 30 && obs_q.size() < exp_q.size(); n++) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fwd_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fwd_sb got %0d/%h want %0d/%h", o.a, o.d, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall_reset();
    wr_t e, o;
    port_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_src(0, 1'b1, 5'(12 + k), 32'h4000 + 32'(k), ALU);
      #1;
      checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL stall_fill%0d got %b want 01", k, src_ready); end
      if (k == 0) exp_q.push_back('{a: 5'd12, d: 32'h4000});
      tick();
    end
    src_valid = '0;
    port_busy = 1'b0;
    tick();
    rdy_in = 1'b0;
    set_src(0, 1'b1, 5'd30, 32'h4030, ALU);
    #1;
    checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL stall_ready got %b want 00", src_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL stall_count%0d got %0d want 3", k, count); end
      checks++; if (write_enable !== 1'b1 || write_addr !== 5'd12 || write_data !== 32'h4000) begin errors++; $display("FAIL stall_hold%0d we %b addr %0d data %h want 1 12 00004000", k, write_enable, write_addr, write_data); end
    end
    src_valid = '0;
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++; if (count !== 3'd0 || write_enable !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL stall_reset count %0d we %b empty %b want 0 0 1", count, write_enable, empty); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL stall_nowrite%0d got %b want 0", k, write_enable); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_sb_size got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_sb got %0d/%h want %0d/%h", o.a, o.d, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_filter();
    test_round_robin();
    test_full();
    test_forward();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised writeback stage with buffering. Collects register-writeback requests from `NSRC` execution/memory producers through a round-robin arbiter. Filters out requests that carry no destination register and queues the rest in a `DEPTH`-entry FIFO. Drains one entry per cycle onto the register-file write port and exposes a forwarding lookup over all pending writes. Sits between the MEM-side producers and the register file, where the single-source combinational writeback stage used to be.

## Interface
Parameters:
- `NSRC`, 2: number of producer channels (≥1).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `XLEN`, 32: data width.

Ports:
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_in`  in  1  reset. Synchronous, active-high.
- `rdy_in`  in  1  global ready. When low, the block holds all state.
- `port_busy`  in  1  register-file port unavailable. When high, no pop occurs; enqueue still allowed.
- `src_valid`  in  NSRC  per-source request valid.
- `src_ready`  out  NSRC  per-source accept.
- `src_rd_addr`  in  NSRC*5  destination register; source i occupies bits [5i+4:5i].
- `src_rd_val`  in  NSRC*XLEN  result value.
- `src_ins_type`  in  NSRC*7  instruction class, using the shared defines encoding.
- `write_enable`  out  1  register-file write strobe (registered).
- `write_addr`  out  5  register-file write address (registered).
- `write_data`  out  XLEN  register-file write data (registered).
- `fwd_addr`  in  5  forwarding query address.
- `fwd_hit`  out  1  a pending write to `fwd_addr` exists (combinational).
- `fwd_data`  out  XLEN  youngest pending value for `fwd_addr`.
- `count`  out  $clog2(DEPTH)+1  current occupancy (registered).
- `empty`  out  1  `count==0`.

## Operation
- **Writing request:** `ins_type` is neither `JMPC` nor `SAVE`, and `rd_addr != 0`. All other requests are non-writing.
- **Arbitration:**
  - Round-robin pointer `rr`, reset value 0.
  - Grant goes to the first valid source at index ≥ `rr`, scanning cyclically.
  - At most one grant per cycle.
- **Ready:** `src_ready[i] = rdy_in & grant[i] & (nonwriting_i | !full | pop)`.
  - `pop = rdy_in & !port_busy & !empty`.
  - `src_ready` depends combinationally on `src_valid`.
- **Handshake:** a handshake on source i sets `rr <= (i+1) mod NSRC`. With no handshake, `rr` is unchanged.
- **Enqueue:** a writing handshake pushes {addr, val} at the FIFO tail. A non-writing handshake completes but consumes no slot.
- **Drain:** on `pop`, the head is removed and registered onto `write_enable=1`, `write_addr`, `write_data`.
  - With `rdy_in=1` and no pop, `write_enable <= 0`, `write_addr <= 0`, `write_data <= 0`.
- **`rdy_in=0`:** no push, no pop, `src_ready=0`, `rr` held. The write-port registers hold their values; a repeated identical write is idempotent.
- **Forwarding:**
  - `fwd_hit=1` if `fwd_addr != 0` and either a valid FIFO entry matches or the write-port register matches with `write_enable=1`.
  - `fwd_data` comes from the youngest matching FIFO entry; if none matches, from the write-port register.
  - An entry being pushed in the current cycle is not visible until the next cycle.
  - On a miss, `fwd_data=0`.
- **Simultaneous push and pop when full:** both happen and `count` is unchanged.
- **Pointer wrap:** head and tail pointers wrap modulo `DEPTH`.

## Timing
- **Reset:** `rst_in` takes priority over `rdy_in`. At the edge, all outputs are registered to 0: `write_enable`, `write_addr`, `write_data`, `count`. `empty` becomes 1, `rr=0`, head and tail are 0, and every entry is invalidated.
- **Reset mid-operation:** pending entries are discarded and never written.
- **Latency, empty FIFO:**
  - Handshake in cycle C.
  - Entry counted in cycle C+1.
  - Popped at the end of C+1, so `write_enable=1` in cycle C+2.
- **Throughput:** one push and one pop per cycle sustained.
- **`port_busy`:** sampled in the pop cycle only. Deasserting it allows a pop in the same cycle.

## Test plan
1. **Single write:** after reset, src0 valid with rd=5, val=0x00001234, type ALU in cycle 1 -> `src_ready[0]=1` in cycle 1; `count=1` in cycle 2; `write_enable=1`, addr 5, data 0x00001234 in cycle 3; `count=0`, `empty=1` in cycle 3.
2. **Filtering:** src0 requests with rd=0 (ALU), rd=3 type `SAVE`, and rd=4 type `JMPC` -> each gets `src_ready=1`; `count` stays 0; `write_enable` never asserts.
3. **Round robin:** NSRC=2, both sources valid continuously, rd=1 / rd=2 -> grants alternate 0,1,0,1; writes appear as addr 1,2,1,2 with no gaps.
4. **Full and simultaneous push/pop:**
   - With `port_busy=1`, push 4 entries -> `count=4` and `src_ready=0` for writing requests, while a `SAVE` request is still accepted.
   - Drop `port_busy` with a writing request valid -> pop and push in the same cycle, `count` stays 4.
5. **Forwarding:** with `port_busy=1`, enqueue rd=7 val=0xA, then rd=7 val=0xB.
   - `fwd_addr=7` -> `fwd_hit=1`, `fwd_data=0xB`.
   - `fwd_addr=0` -> `fwd_hit=0`.
   - `fwd_addr=8` -> `fwd_hit=0`, `fwd_data=0`.
6. **Stall and reset:**
   - 3 entries queued, `rdy_in=0` for 2 cycles -> `count` is unchanged and the write port is held.
   - `rst_in=1` for one cycle -> next cycle `count=0`, `write_enable=0`, `empty=1`; no further writes.
